audio_frame_mixer: RTL

//   Multi-voice stereo mixer between music_player voices and the adau1761_codec sample path.

---
 rtl/audio_mixer_pkg.sv | 25 ++
 rtl/sample_fifo.sv | 46 ++++
 rtl/audio_frame_mixer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/audio_mixer_pkg.sv
// Shared types and helpers for the audio frame mixer: FSM encoding,
// unity-gain constant and the output saturation function.
package audio_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } mix_state_t;

  localparam int MIXER_GAIN_W = 4;
  localparam int UNITY        = 1 << (MIXER_GAIN_W - 1);

  // Clamp a sign-extended accumulator value to a w-bit signed range.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      saturate = hi;
    else if (v < lo) saturate = lo;
    else             saturate = v;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with registered pointers; same-cycle push and pop both
// take effect. rdata shows the head entry combinationally.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/audio_frame_mixer.sv
// N-voice stereo mixer: per-channel FIFOs, per-channel gain, one saturated
// stereo sum per codec frame. Define MIXER_PEAK_EN to build the peak meters.
//
// state  | meaning
// IDLE   | waiting for new_frame
// ACCUM  | one channel per cycle: pop, scale, accumulate
// OUTPUT | saturate accumulators, register outputs, pulse out_valid
module audio_frame_mixer
  import audio_mixer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int GAIN_W     = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH*SAMPLE_W-1:0]   in_left,
  input  logic [NUM_CH*SAMPLE_W-1:0]   in_right,
  input  logic [NUM_CH*GAIN_W-1:0]     gain,
  input  logic                         new_frame,
  input  logic                         clear_flags,
  output logic signed [SAMPLE_W-1:0]   out_left,
  output logic signed [SAMPLE_W-1:0]   out_right,
  output logic                         out_valid,
  output logic [NUM_CH-1:0]            underflow,
  output logic                         frame_overrun,
  output logic [SAMPLE_W-1:0]          peak_left,
  output logic [SAMPLE_W-1:0]          peak_right
);

  localparam int PW    = SAMPLE_W + GAIN_W + 1;
  localparam int ACC_W = SAMPLE_W + GAIN_W + $clog2(NUM_CH) + 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  mix_state_t state;
  mix_state_t state_nx;

  logic [CH_W-1:0]           ch_idx;
  logic [NUM_CH-1:0]         fifo_full;
  logic [NUM_CH-1:0]         fifo_empty;
  logic [NUM_CH-1:0]         pop;
  logic [NUM_CH-1:0]         uf_set;
  logic [2*SAMPLE_W-1:0]     fifo_rdata [NUM_CH];
  logic [GAIN_W-1:0]         gain_q [NUM_CH];
  logic signed [ACC_W-1:0]   acc_l;
  logic signed [ACC_W-1:0]   acc_r;
  logic                      start;
  logic                      last_ch;
  logic                      cur_empty;
  logic signed [SAMPLE_W-1:0] cur_l;
  logic signed [SAMPLE_W-1:0] cur_r;
  logic [GAIN_W-1:0]         cur_gain;
  logic signed [PW-1:0]      prod_l;
  logic signed [PW-1:0]      prod_r;
  logic signed [ACC_W-1:0]   term_l;
  logic signed [ACC_W-1:0]   term_r;

  assign in_ready = ~fifo_full;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    sample_fifo #(
      .WIDTH (2 * SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (in_valid[gi]),
      .pop     (pop[gi]),
      .wdata   ({in_left[gi*SAMPLE_W +: SAMPLE_W], in_right[gi*SAMPLE_W +: SAMPLE_W]}),
      .rdata   (fifo_rdata[gi]),
      .full    (fifo_full[gi]),
      .empty   (fifo_empty[gi])
    );
  end

  // Gain is zero-extended so the product stays signed.
  assign cur_empty = fifo_empty[ch_idx];
  assign cur_l     = fifo_rdata[ch_idx][2*SAMPLE_W-1:SAMPLE_W];
  assign cur_r     = fifo_rdata[ch_idx][SAMPLE_W-1:0];
  assign cur_gain  = gain_q[ch_idx];
  assign prod_l    = PW'(cur_l) * PW'($signed({1'b0, cur_gain}));
  assign prod_r    = PW'(cur_r) * PW'($signed({1'b0, cur_gain}));
  assign term_l    = cur_empty ? '0 : ACC_W'(prod_l >>> (GAIN_W - 1));
  assign term_r    = cur_empty ? '0 : ACC_W'(prod_r >>> (GAIN_W - 1));
  assign last_ch   = (ch_idx == CH_W'(NUM_CH - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    pop      = '0;
    uf_set   = '0;
    case (state)
      IDLE: begin
        if (new_frame) begin
          state_nx = ACCUM;
          start    = 1'b1;
        end
      end
      ACCUM: begin
        if (cur_empty) uf_set[ch_idx] = 1'b1;
        else           pop[ch_idx]    = 1'b1;
        if (last_ch) state_nx = OUTPUT;
      end
      OUTPUT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ch_idx        <= '0;
      acc_l         <= '0;
      acc_r         <= '0;
      out_left      <= '0;
      out_right     <= '0;
      out_valid     <= 1'b0;
      underflow     <= '0;
      frame_overrun <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) gain_q[k] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (start) begin
        ch_idx <= '0;
        acc_l  <= '0;
        acc_r  <= '0;
        for (int k = 0; k < NUM_CH; k++) gain_q[k] <= gain[k*GAIN_W +: GAIN_W];
      end
      if (state == ACCUM) begin
        acc_l  <= acc_l + term_l;
        acc_r  <= acc_r + term_r;
        ch_idx <= ch_idx + 1'b1;
      end
      if (state == OUTPUT) begin
        out_left  <= SAMPLE_W'(saturate(64'(acc_l), SAMPLE_W));
        out_right <= SAMPLE_W'(saturate(64'(acc_r), SAMPLE_W));
        out_valid <= 1'b1;
      end
      // A flag event in the same cycle as clear_flags leaves the flag set.
      underflow     <= (underflow & ~{NUM_CH{clear_flags}}) | uf_set;
      frame_overrun <= (frame_overrun & ~clear_flags) | (new_frame && (state != IDLE));
    end
  end

`ifdef MIXER_PEAK_EN
  localparam logic [SAMPLE_W-1:0] MAG_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] NEG_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [SAMPLE_W-1:0] abs_l;
  logic [SAMPLE_W-1:0] abs_r;

  // Most negative sample has no positive twin; report it as full scale.
  assign abs_l = !out_left[SAMPLE_W-1]  ? out_left  :
                 (out_left == NEG_MIN)  ? MAG_MAX : (~out_left + 1'b1);
  assign abs_r = !out_right[SAMPLE_W-1] ? out_right :
                 (out_right == NEG_MIN) ? MAG_MAX : (~out_right + 1'b1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      peak_left  <= '0;
      peak_right <= '0;
    end else begin
      if (clear_flags) begin
        peak_left  <= '0;
        peak_right <= '0;
      end
      if (out_valid && (clear_flags || abs_l > peak_left))  peak_left  <= abs_l;
      if (out_valid && (clear_flags || abs_r > peak_right)) peak_right <= abs_r;
    end
  end
`else
  assign peak_left  = '0;
  assign peak_right = '0;
`endif

endmodule
